// File: rtl/audio_pkg.sv
// audio_pkg: types shared by the audio stream scheduler and the processing
// datapath.
//   AUDIO_DW      default sample width per channel
//   sched_state_t scheduler FSM state (IDLE / SEND / WAIT)
//   stereo_t      one stereo sample {left, right} at the default width
package audio_pkg;

  localparam int unsigned AUDIO_DW = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [AUDIO_DW-1:0] left;
    logic [AUDIO_DW-1:0] right;
  } stereo_t;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO for stereo samples (2*DW bits per entry).
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_data  write one entry (ignored when full)
//   pop              drop the head entry (ignored when empty)
//   head             current head entry, read combinationally from storage
//   count            number of stored entries (0..DEPTH)
//   full, empty      status flags
module sample_fifo #(
  parameter int unsigned DW    = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [2*DW-1:0]            push_data,
  input  logic                       pop,
  output logic [2*DW-1:0]            head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [2*DW-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/audio_stream_sched.sv
// audio_stream_sched: moves stereo samples codec -> datapath -> output FIFO
// -> codec, with at most one sample in flight through the datapath.
//   CLOCK_50, reset         clock, asynchronous active-low reset
//   enable                  start new samples (0 finishes the one in flight)
//   read_ready/read         codec input handshake, readdata_* input sample
//   write_ready/write       codec output handshake, writedata_* = FIFO head
//   proc_valid/proc_ready   sample offer to datapath on proc_*
//   res_valid/res_ready     result from datapath on res_*
//   busy                    a sample is in flight
//   underrun_cnt            saturating count of starved write slots
module audio_stream_sched
  import audio_pkg::*;
#(
  parameter int unsigned DW         = 24,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             enable,
  input  logic             read_ready,
  output logic             read,
  input  logic [DW-1:0]    readdata_left,
  input  logic [DW-1:0]    readdata_right,
  input  logic             write_ready,
  output logic             write,
  output logic [DW-1:0]    writedata_left,
  output logic [DW-1:0]    writedata_right,
  output logic             proc_valid,
  input  logic             proc_ready,
  output logic [DW-1:0]    proc_left,
  output logic [DW-1:0]    proc_right,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [DW-1:0]    res_left,
  input  logic [DW-1:0]    res_right,
  output logic             busy,
  output logic [CNT_W-1:0] underrun_cnt
);

  sched_state_t                  state;
  logic                          fifo_push;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [2*DW-1:0]               fifo_head;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  // read is combinational from IDLE, and IDLE is also the reset state, so it
  // is qualified with reset to keep the pulse off while reset is held.
  assign read       = reset & (state == IDLE) & enable & read_ready & ~fifo_full;
  assign proc_valid = (state == SEND);
  assign res_ready  = (state == WAIT);
  assign busy       = (state != IDLE);
  assign fifo_push  = res_valid & res_ready;
  assign write      = write_ready & ~fifo_empty;

  assign writedata_left  = fifo_head[2*DW-1:DW];
  assign writedata_right = fifo_head[DW-1:0];

  sample_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLOCK_50),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data ({res_left, res_right}),
    .pop       (write),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      proc_left  <= '0;
      proc_right <= '0;
    end else begin
      case (state)
        IDLE: if (read) begin
          state      <= SEND;
          proc_left  <= readdata_left;
          proc_right <= readdata_right;
        end
        SEND:    if (proc_ready) state <= WAIT;
        WAIT:    if (res_valid)  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      underrun_cnt <= '0;
    end else if (enable && write_ready && fifo_empty && (underrun_cnt != '1)) begin
      underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_audio_stream_sched.sv
module tb_audio_stream_sched;

  localparam int DW    = 24;
  localparam int DEPTH = 4;

  logic          CLOCK_50 = 1'b0;
  logic          reset, enable, read_ready, write_ready, proc_ready, res_valid;
  logic [DW-1:0] readdata_left, readdata_right, res_left, res_right;
  logic          read, write, proc_valid, res_ready, busy;
  logic [DW-1:0] writedata_left, writedata_right, proc_left, proc_right;
  logic [15:0]   underrun_cnt;

  audio_stream_sched #(.DW(DW), .FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable),
    .read_ready(read_ready), .read(read),
    .readdata_left(readdata_left), .readdata_right(readdata_right),
    .write_ready(write_ready), .write(write),
    .writedata_left(writedata_left), .writedata_right(writedata_right),
    .proc_valid(proc_valid), .proc_ready(proc_ready),
    .proc_left(proc_left), .proc_right(proc_right),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_left(res_left), .res_right(res_right),
    .busy(busy), .underrun_cnt(underrun_cnt)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a sample's life is none -> offered -> processing -> none,
  // and the output buffer is a plain queue of {left,right} words.
  localparam int NONE = 0, OFFERED = 1, PROCESSING = 2;
  int          life;
  logic [47:0] outq[$];
  logic [47:0] held;
  int          ucnt;

  function automatic bit pred_read();
    return reset && life == NONE && enable && read_ready && outq.size() < DEPTH;
  endfunction
  function automatic bit pred_write();
    return write_ready && outq.size() != 0;
  endfunction

  // Compare every output with the model at the falling edge.
  task automatic mcheck();
    @(negedge CLOCK_50);
    if (!reset) begin
      life = NONE; outq.delete(); held = '0; ucnt = 0;
    end
    chk("read",       {63'd0, read},       {63'd0, pred_read()});
    chk("write",      {63'd0, write},      {63'd0, pred_write()});
    chk("proc_valid", {63'd0, proc_valid}, {63'd0, reset && life == OFFERED});
    chk("res_ready",  {63'd0, res_ready},  {63'd0, reset && life == PROCESSING});
    chk("busy",       {63'd0, busy},       {63'd0, reset && life != NONE});
    chk("proc_data",  {16'd0, proc_left, proc_right}, {16'd0, held});
    chk("underrun",   {48'd0, underrun_cnt}, 64'(ucnt));
    if (pred_write())
      chk("writedata", {16'd0, writedata_left, writedata_right}, {16'd0, outq[0]});
  endtask

  task automatic tick();
    bit rd, wr, was_empty;
    @(posedge CLOCK_50);
    if (reset) begin
      rd = pred_read(); wr = pred_write(); was_empty = (outq.size() == 0);
      if (wr) void'(outq.pop_front());
      if (life == PROCESSING && res_valid) outq.push_back({res_left, res_right});
      if (enable && write_ready && was_empty && ucnt < 65535) ucnt++;
      case (life)
        NONE:    if (rd) begin held = {readdata_left, readdata_right}; life = OFFERED; end
        OFFERED: if (proc_ready) life = PROCESSING;
        default: if (res_valid) life = NONE;
      endcase
    end
    #1;
  endtask

  task automatic cyc();
    mcheck();
    tick();
  endtask

  // Present one sample with an echoing datapath and wait for it to complete.
  task automatic feed(input logic [DW-1:0] v);
    bit got = 0;
    readdata_left = v; readdata_right = v + 1;
    res_left = v; res_right = v + 1;
    read_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      mcheck(); got = read; tick();
    end
    read_ready = 1'b0;
    chk("feed_read", {63'd0, got}, 64'd1);
    for (int i = 0; i < 20 && busy; i++) cyc();
    chk("feed_done", {63'd0, busy}, 64'd0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) cyc();
    reset = 1'b1;
  endtask

  typedef struct {
    logic en, rr, wrdy, prdy, rv;
    logic [DW-1:0] rd, rs;
    logic e_rd, e_wr, e_pv, e_rres, e_busy;
    logic [DW-1:0] e_proc, e_wd;
  } vec_t;
  vec_t tbl[5];

  initial begin
    //            en rr wr pr rv  rd  rs  rd wr pv rr busy proc wd
    tbl[0] = '{1, 1, 1, 1, 1, 64, 64, 1, 0, 0, 0, 0,  0,  0};
    tbl[1] = '{1, 0, 1, 1, 1, 0,  64, 0, 0, 1, 0, 1,  64, 0};
    tbl[2] = '{1, 0, 1, 1, 1, 0,  64, 0, 0, 0, 1, 1,  64, 0};
    tbl[3] = '{1, 0, 1, 1, 1, 0,  64, 0, 1, 0, 0, 0,  64, 64};
    tbl[4] = '{1, 0, 1, 1, 1, 0,  64, 0, 0, 0, 0, 0,  64, 0};

    life = NONE; held = '0; ucnt = 0;
    reset = 1'b0; enable = 1'b1; read_ready = 1'b1; write_ready = 1'b1;
    proc_ready = 1'b1; res_valid = 1'b1;
    readdata_left = 24'h5; readdata_right = 24'h6; res_left = '0; res_right = '0;

    // Reset held with both readies high.
    for (int i = 0; i < 6; i++) begin
      mcheck();
      chk("rst_read",  {63'd0, read},  64'd0);
      chk("rst_write", {63'd0, write}, 64'd0);
      chk("rst_busy",  {63'd0, busy},  64'd0);
      chk("rst_pv",    {63'd0, proc_valid}, 64'd0);
      chk("rst_ucnt",  {48'd0, underrun_cnt}, 64'd0);
      tick();
    end
    reset = 1'b1;

    // Single pass, zero-wait echo datapath.
    for (int i = 0; i < 5; i++) begin
      enable = tbl[i].en; read_ready = tbl[i].rr; write_ready = tbl[i].wrdy;
      proc_ready = tbl[i].prdy; res_valid = tbl[i].rv;
      readdata_left = tbl[i].rd; readdata_right = tbl[i].rd;
      res_left = tbl[i].rs; res_right = tbl[i].rs;
      mcheck();
      chk("tbl_read",  {63'd0, read},       {63'd0, tbl[i].e_rd});
      chk("tbl_write", {63'd0, write},      {63'd0, tbl[i].e_wr});
      chk("tbl_pv",    {63'd0, proc_valid}, {63'd0, tbl[i].e_pv});
      chk("tbl_rres",  {63'd0, res_ready},  {63'd0, tbl[i].e_rres});
      chk("tbl_busy",  {63'd0, busy},       {63'd0, tbl[i].e_busy});
      chk("tbl_proc",  {40'd0, proc_left},  {40'd0, tbl[i].e_proc});
      if (tbl[i].e_wr) begin
        chk("tbl_wd_l", {40'd0, writedata_left},  {40'd0, tbl[i].e_wd});
        chk("tbl_wd_r", {40'd0, writedata_right}, {40'd0, tbl[i].e_wd});
      end
      tick();
    end

    // Fill the output FIFO with write_ready low, then drain in order.
    write_ready = 1'b0;
    feed(64); feed(128); feed(192); feed(256);
    readdata_left = 24'd320; read_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mcheck();
      chk("full_no_read", {63'd0, read}, 64'd0);
      tick();
    end
    read_ready = 1'b0; write_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mcheck();
      chk("drain_write", {63'd0, write}, 64'd1);
      chk("drain_data",  {40'd0, writedata_left}, 64'(64 * (i + 1)));
      tick();
    end
    cyc();

    // Datapath stall: proc_valid and proc_* held, no second read.
    readdata_left = 24'd128; readdata_right = 24'd129;
    res_left = 24'd128; res_right = 24'd129;
    proc_ready = 1'b0; read_ready = 1'b1;
    for (int i = 0; i < 10 && !read; i++) cyc();
    mcheck(); tick();
    readdata_left = 24'd999;
    for (int i = 0; i < 5; i++) begin
      mcheck();
      chk("stall_pv",   {63'd0, proc_valid}, 64'd1);
      chk("stall_proc", {40'd0, proc_left},  64'd128);
      chk("stall_read", {63'd0, read},       64'd0);
      tick();
    end
    read_ready = 1'b0; proc_ready = 1'b1;
    for (int i = 0; i < 6; i++) cyc();

    // Underrun counting and saturation.
    do_reset(2);
    enable = 1'b1; write_ready = 1'b1; read_ready = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    mcheck();
    chk("underrun_10", {48'd0, underrun_cnt}, 64'd10);
    tick();
    for (int i = 0; i < 65535; i++) cyc();
    mcheck();
    chk("underrun_sat", {48'd0, underrun_cnt}, 64'hFFFF);
    tick();
    for (int i = 0; i < 3; i++) cyc();
    mcheck();
    chk("underrun_hold", {48'd0, underrun_cnt}, 64'hFFFF);
    tick();

    // Reset while a sample waits for its result, with two entries buffered.
    do_reset(1);
    write_ready = 1'b0;
    feed(100); feed(101);
    readdata_left = 24'd150; readdata_right = 24'd151; res_valid = 1'b0;
    read_ready = 1'b1;
    for (int i = 0; i < 10 && !read; i++) cyc();
    mcheck(); tick();
    read_ready = 1'b0;
    cyc();
    mcheck();
    chk("wait_rres", {63'd0, res_ready}, 64'd1);
    tick();
    reset = 1'b0; write_ready = 1'b1;
    #1;
    chk("rst_mid_write", {63'd0, write},     64'd0);
    chk("rst_mid_busy",  {63'd0, busy},      64'd0);
    chk("rst_mid_rres",  {63'd0, res_ready}, 64'd0);
    cyc();
    reset = 1'b1; res_valid = 1'b1; write_ready = 1'b0;
    feed(192);
    write_ready = 1'b1;
    mcheck();
    chk("post_rst_write", {63'd0, write}, 64'd1);
    chk("post_rst_data",  {40'd0, writedata_left}, 64'd192);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(199) != 0);
      enable      = ($urandom_range(9) != 0);
      read_ready  = ($urandom_range(9) < 6);
      write_ready = ($urandom_range(1) == 1);
      proc_ready  = ($urandom_range(9) < 7);
      res_valid   = ($urandom_range(9) < 7);
      readdata_left  = DW'($urandom); readdata_right = DW'($urandom);
      res_left       = DW'($urandom); res_right      = DW'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_stream_sched.md
# audio_stream_sched

Sequencing controller between the audio codec FIFO port and the sample-processing datapath. It pulls one stereo sample from the codec when input data is available and hands it to the datapath over a valid/ready handshake. It collects the processed result, buffers it in a small output FIFO and drains that FIFO into the codec whenever the codec can accept data. It sits in the top level between the codec core and the processing circuit and replaces the ad-hoc read/write gating.

## Interface
Parameters:
- DW, 24, sample width per channel
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)
- CNT_W, 16, width of the underrun counter

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset: 0 clears all state immediately; release is synchronous to CLOCK_50
- enable  in  1  1 = start new samples; 0 = finish the sample in flight, then idle
- read_ready  in  1  codec has an input sample
- read  out  1  one-cycle acknowledge that pops the codec input sample
- readdata_left / readdata_right  in  DW  codec input sample
- write_ready  in  1  codec can accept an output sample
- write  out  1  one-cycle strobe that pushes writedata_* into the codec
- writedata_left / writedata_right  out  DW  codec output sample
- proc_valid  out  1  sample offered to the datapath
- proc_ready  in  1  datapath accepts the sample
- proc_left / proc_right  out  DW  sample to the datapath
- res_valid  in  1  datapath result available
- res_ready  out  1  controller accepts the result
- res_left / res_right  in  DW  datapath result
- busy  out  1  state ≠ IDLE
- underrun_cnt  out  CNT_W  saturating count of starved write slots

## Operation
- FSM states: IDLE, SEND, WAIT.
- IDLE → SEND when enable=1, read_ready=1 and fifo_count < FIFO_DEPTH.
  - read=1 for exactly that cycle.
  - readdata_* is latched into proc_* on the same edge.
- SEND: proc_valid=1 and proc_* are held stable. On proc_valid & proc_ready, go to WAIT.
- WAIT: res_ready=1. On res_valid & res_ready, push res_* into the FIFO and return to IDLE.
- At most one sample is in flight. The FIFO space check in IDLE guarantees the push never overflows.
- Write side runs independently of the FSM:
  - write = write_ready & (fifo_count ≠ 0).
  - writedata_* = FIFO head, combinational from the storage register.
  - The FIFO pops on write.
- Push and pop in the same cycle: fifo_count is unchanged and both pointers advance, wrapping modulo FIFO_DEPTH.
- Underrun: underrun_cnt +1 in any cycle with enable=1, write_ready=1 and FIFO empty. It saturates at all-ones and never wraps.
- enable falling in SEND or WAIT: the current sample completes and is pushed. No further read occurs. The FIFO keeps draining.
- Samples pass through unmodified. No width change.

## Timing
- Reset values: read=0, write=0, proc_valid=0, res_ready=0, busy=0, proc_*=0, writedata_*=0, underrun_cnt=0, FIFO empty, state IDLE.
- Reset asserted mid-operation: the in-flight sample and FIFO contents are discarded immediately. No read or write pulse is generated in the reset cycle.
- Latency with zero-wait datapath (proc_ready=1, res_valid=1):
  - read in cycle N; SEND in N+1; WAIT in N+2; FIFO push at end of N+2.
  - write possible in N+3; next read possible in N+3.
- read and write are each never high for two consecutive cycles without the corresponding ready being high in both.
- proc_* and proc_valid must not change while proc_valid=1 and proc_ready=0.

## Structure
- Package audio_pkg: DW default, the FSM state enum (IDLE/SEND/WAIT), and a stereo sample struct {left, right} shared with the processing datapath.
- Sub-module sample_fifo: parameterised DW×2-wide synchronous FIFO with push, pop, head, count, full and empty outputs, plus the same asynchronous active-low reset. The FSM, handshakes and counter stay in audio_stream_sched.

## Test plan
- Reset: hold reset=0 for 6 cycles with read_ready=1 and write_ready=1 → all outputs are 0, underrun_cnt=0, no read or write pulse.
- Single pass, zero-wait datapath echoing input:
  - Stimulus: enable=1, read_ready=1, readdata=64/64.
  - Response: read pulse, proc_*=64 one cycle later, write with writedata=64/64 three cycles after read.
- Stream 64, 128, 192, 256 with write_ready=0:
  - FIFO fills to 4 and read stops.
  - Raising write_ready then yields writes of 64, 128, 192, 256 in order on consecutive cycles.
- Datapath stall: proc_ready=0 for 5 cycles → proc_valid held and proc_* stable at 128, no second read. Then proc_ready=1 completes the sample normally.
- Underrun: enable=1, write_ready=1, read_ready=0 for 10 cycles → underrun_cnt=10, write never asserted. A preloaded 0xFFFF counter stays at 0xFFFF.
- Reset asserted in WAIT with 2 FIFO entries → state IDLE, FIFO empty, write=0 immediately. After release, the next sample (192) is the first one written.
